// File: rtl/caf_pkg.sv
// Shared constants for the CAF read sequencer: FSM encodings, stream packing offsets, clog2.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package caf_pkg;

   // Sequencer FSM encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_EMIT = 3'd3;
   localparam logic [2:0] ST_FIN  = 3'd4;

   // Ceiling log2 with a floor of 1 so single-value fields still get a bit
   function automatic int caf_clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   // Stream beat layout, LSB first: ref_i, ref_q, cap_i, cap_q
   function automatic int caf_off_ref_q(input int ri);
      return ri;
   endfunction

   function automatic int caf_off_cap_i(input int ri, input int rq);
      return ri + rq;
   endfunction

   function automatic int caf_off_cap_q(input int ri, input int rq, input int ci);
      return ri + rq + ci;
   endfunction

endpackage

// File: rtl/caf_read_chan.sv
// One buffer read channel: address handshake, then data handshake into holding regs.
// Latency: address offered the cycle addr_en rises; data held the edge after rvalid&rready.
// Backpressure: address held until arready; rready held until rvalid; issue re-arms the channel.
module caf_read_chan #(
   parameter int ADDR_BITS = 6,
   parameter int I_BITS    = 12,
   parameter int Q_BITS    = 12
) (
   input  logic                 clk_i,
   input  logic                 n_reset_i,
   input  logic                 issue_i,
   input  logic                 addr_en_i,
   input  logic                 data_en_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   output logic [ADDR_BITS-1:0] raddr_o,
   output logic                 arvalid_o,
   input  logic                 arready_i,
   output logic                 rready_o,
   input  logic                 rvalid_i,
   input  logic [I_BITS-1:0]    d_re_i,
   input  logic [Q_BITS-1:0]    d_im_i,
   output logic                 acc_q_o,
   output logic                 acc_now_o,
   output logic                 got_now_o,
   output logic [I_BITS-1:0]    held_re_o,
   output logic [Q_BITS-1:0]    held_im_o
);

   logic              acc_q;
   logic              got_q;
   logic [I_BITS-1:0] re_q;
   logic [Q_BITS-1:0] im_q;
   logic              addr_hs;
   logic              data_hs;

   // Handshake qualifiers; valid/ready drop once this channel has completed its own phase
   always_comb begin
      raddr_o   = addr_i;
      arvalid_o = addr_en_i & ~acc_q;
      addr_hs   = arvalid_o & arready_i;
      acc_now_o = acc_q | addr_hs;
      rready_o  = data_en_i & ~got_q;
      data_hs   = rready_o & rvalid_i;
      got_now_o = got_q | data_hs;
      acc_q_o   = acc_q;
      held_re_o = re_q;
      held_im_o = im_q;
   end

   // Phase flags and sample holding registers; issue re-arms both flags for a new beat
   always_ff @(posedge clk_i) begin
      if (!n_reset_i) begin
         acc_q <= 1'b0;
         got_q <= 1'b0;
         re_q  <= '0;
         im_q  <= '0;
      end else if (issue_i) begin
         acc_q <= 1'b0;
         got_q <= 1'b0;
      end else begin
         if (addr_hs) acc_q <= 1'b1;
         if (data_hs) begin
            got_q <= 1'b1;
            re_q  <= d_re_i;
            im_q  <= d_im_i;
         end
      end
   end

endmodule

// File: rtl/caf_read_sequencer.sv
// Lag sweep sequencer: pairs ref[n] with cap[n+k] and streams them as one beat each.
// Latency: 3 cycles per beat minimum (ADDR, DATA, EMIT); done 1 cycle after the last beat.
// Backpressure: beat held stable until tready; no new buffer read issued before the handshake.
module caf_read_sequencer
   import caf_pkg::*;
#(
   parameter int REF_LEN       = 64,
   parameter int N_LAGS        = 16,
   parameter int REF_ADDR_BITS = 6,
   parameter int CAP_ADDR_BITS = 7,
   parameter int REF_I_BITS    = 12,
   parameter int REF_Q_BITS    = 12,
   parameter int REC_I_BITS    = 12,
   parameter int REC_Q_BITS    = 12
) (
   input  logic                                                       clk,
   input  logic                                                       n_reset,
   input  logic                                                       start,
   input  logic                                                       abort,
   output logic                                                       busy,
   output logic                                                       done,
   output logic [REF_ADDR_BITS-1:0]                                   m_axi_ref_raddr,
   output logic                                                       m_axi_ref_rvalid,
   input  logic                                                       s_axi_ref_rready,
   output logic                                                       m_axi_ref_rready,
   input  logic                                                       s_axi_ref_rvalid,
   input  logic [REF_I_BITS-1:0]                                      ref_i,
   input  logic [REF_Q_BITS-1:0]                                      ref_q,
   output logic [CAP_ADDR_BITS-1:0]                                   m_axi_cap_raddr,
   output logic                                                       m_axi_cap_rvalid,
   input  logic                                                       s_axi_cap_rready,
   output logic                                                       m_axi_cap_rready,
   input  logic                                                       s_axi_cap_rvalid,
   input  logic [REC_I_BITS-1:0]                                      cap_i,
   input  logic [REC_Q_BITS-1:0]                                      cap_q,
   output logic                                                       s_axis_tvalid,
   output logic [REF_I_BITS+REF_Q_BITS+REC_I_BITS+REC_Q_BITS-1:0]     s_axis_tdata,
   output logic                                                       s_axis_tlast,
   output logic [caf_clog2(N_LAGS)-1:0]                               s_axis_tuser,
   input  logic                                                       m_axis_tready
);

   localparam int KW        = caf_clog2(N_LAGS);
   localparam int OFF_REF_Q = caf_off_ref_q(REF_I_BITS);
   localparam int OFF_CAP_I = caf_off_cap_i(REF_I_BITS, REF_Q_BITS);
   localparam int OFF_CAP_Q = caf_off_cap_q(REF_I_BITS, REF_Q_BITS, REC_I_BITS);

   logic [2:0]               state_q, state_d;
   logic [REF_ADDR_BITS-1:0] n_q, n_d;
   logic [KW-1:0]            k_q, k_d;
   logic                     abort_q, abort_d;
   logic                     issue;
   logic                     addr_en, data_en, abort_stop;
   logic                     last_n, last_k;
   logic [CAP_ADDR_BITS-1:0] cap_addr;

   logic                     ref_acc_q, ref_acc_now, ref_got_now;
   logic                     cap_acc_q, cap_acc_now, cap_got_now;
   logic [REF_I_BITS-1:0]    ref_re_h;
   logic [REF_Q_BITS-1:0]    ref_im_h;
   logic [REC_I_BITS-1:0]    cap_re_h;
   logic [REC_Q_BITS-1:0]    cap_im_h;

   // Channel enables; a latched abort withdraws the address phase only if neither channel has committed
   always_comb begin
      abort_stop = abort_q & ~ref_acc_q & ~cap_acc_q;
      addr_en    = (state_q == ST_ADDR) & ~abort_stop;
      data_en    = (state_q == ST_DATA);
      last_n     = (n_q == REF_ADDR_BITS'(REF_LEN - 1));
      last_k     = (k_q == KW'(N_LAGS - 1));
      cap_addr   = CAP_ADDR_BITS'(n_q) + CAP_ADDR_BITS'(k_q);
   end

   caf_read_chan #(
      .ADDR_BITS (REF_ADDR_BITS),
      .I_BITS    (REF_I_BITS),
      .Q_BITS    (REF_Q_BITS)
   ) u_ref_chan (
      .clk_i     (clk),
      .n_reset_i (n_reset),
      .issue_i   (issue),
      .addr_en_i (addr_en),
      .data_en_i (data_en),
      .addr_i    (n_q),
      .raddr_o   (m_axi_ref_raddr),
      .arvalid_o (m_axi_ref_rvalid),
      .arready_i (s_axi_ref_rready),
      .rready_o  (m_axi_ref_rready),
      .rvalid_i  (s_axi_ref_rvalid),
      .d_re_i    (ref_i),
      .d_im_i    (ref_q),
      .acc_q_o   (ref_acc_q),
      .acc_now_o (ref_acc_now),
      .got_now_o (ref_got_now),
      .held_re_o (ref_re_h),
      .held_im_o (ref_im_h)
   );

   caf_read_chan #(
      .ADDR_BITS (CAP_ADDR_BITS),
      .I_BITS    (REC_I_BITS),
      .Q_BITS    (REC_Q_BITS)
   ) u_cap_chan (
      .clk_i     (clk),
      .n_reset_i (n_reset),
      .issue_i   (issue),
      .addr_en_i (addr_en),
      .data_en_i (data_en),
      .addr_i    (cap_addr),
      .raddr_o   (m_axi_cap_raddr),
      .arvalid_o (m_axi_cap_rvalid),
      .arready_i (s_axi_cap_rready),
      .rready_o  (m_axi_cap_rready),
      .rvalid_i  (s_axi_cap_rvalid),
      .d_re_i    (cap_i),
      .d_im_i    (cap_q),
      .acc_q_o   (cap_acc_q),
      .acc_now_o (cap_acc_now),
      .got_now_o (cap_got_now),
      .held_re_o (cap_re_h),
      .held_im_o (cap_im_h)
   );

   // Sweep FSM: counters advance only on the stream handshake, abort resolves at safe points
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      k_d     = k_q;
      abort_d = abort_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ADDR;
               n_d     = '0;
               k_d     = '0;
               abort_d = abort;
               issue   = 1'b1;
            end
         end
         ST_ADDR: begin
            if (abort) abort_d = 1'b1;
            if (abort_stop) state_d = ST_FIN;
            else if (ref_acc_now && cap_acc_now) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (abort) abort_d = 1'b1;
            if (ref_got_now && cap_got_now) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (abort) abort_d = 1'b1;
            if (m_axis_tready) begin
               if (abort_q || abort) begin
                  state_d = ST_FIN;
               end else if (!last_n) begin
                  n_d     = n_q + 1'b1;
                  state_d = ST_ADDR;
                  issue   = 1'b1;
               end else if (!last_k) begin
                  n_d     = '0;
                  k_d     = k_q + 1'b1;
                  state_d = ST_ADDR;
                  issue   = 1'b1;
               end else begin
                  state_d = ST_FIN;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
         end
      endcase
   end

   // State, lag/sample counters and sticky abort
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         k_q     <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         k_q     <= k_d;
         abort_q <= abort_d;
      end
   end

   // Status and stream outputs; tdata comes straight from the holding registers so it is stable in EMIT
   always_comb begin
      busy          = (state_q == ST_ADDR) | (state_q == ST_DATA) | (state_q == ST_EMIT);
      done          = (state_q == ST_FIN);
      s_axis_tvalid = (state_q == ST_EMIT);
      s_axis_tlast  = (state_q == ST_EMIT) & last_n;
      s_axis_tuser  = k_q;
      s_axis_tdata  = '0;
      s_axis_tdata[0 +: REF_I_BITS]         = ref_re_h;
      s_axis_tdata[OFF_REF_Q +: REF_Q_BITS] = ref_im_h;
      s_axis_tdata[OFF_CAP_I +: REC_I_BITS] = cap_re_h;
      s_axis_tdata[OFF_CAP_Q +: REC_Q_BITS] = cap_im_h;
   end

endmodule

// File: doc/caf_read_sequencer.md
Name: caf_read_sequencer

Overview:
- Sequences the CAF datapath's two sample stores, the reference buffer and the capture buffer, for one full lag sweep.
- For each lag k in 0..N_LAGS-1 and sample n in 0..REF_LEN-1:
  - fetches reference sample n and capture sample n+k over the buffers' AXI-lite-style read channels;
  - pairs the two results;
  - emits the pair as one AXI-stream beat to the correlator/FFT stage.
- Sits inside caf between the two buffer instances and the downstream stream interface.

Parameters:
- REF_LEN, 64, reference samples per lag (>=2).
- N_LAGS, 16, number of lags swept (>=1).
- REF_ADDR_BITS, 6, reference buffer address width; 2^REF_ADDR_BITS >= REF_LEN.
- CAP_ADDR_BITS, 7, capture buffer address width; 2^CAP_ADDR_BITS >= REF_LEN+N_LAGS-1.
- REF_I_BITS, 12, reference I width.
- REF_Q_BITS, 12, reference Q width.
- REC_I_BITS, 12, capture I width.
- REC_Q_BITS, 12, capture Q width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- n_reset  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  ends the sweep at the next safe point.
- busy  out  1  high from start acceptance until return to IDLE.
- done  out  1  one-cycle pulse when a sweep completes or aborts.
- m_axi_ref_raddr  out  REF_ADDR_BITS  reference read address.
- m_axi_ref_rvalid  out  1  reference address valid.
- s_axi_ref_rready  in  1  reference buffer accepts the address.
- m_axi_ref_rready  out  1  sequencer ready for reference data.
- s_axi_ref_rvalid  in  1  reference data valid.
- ref_i  in  REF_I_BITS  reference I data.
- ref_q  in  REF_Q_BITS  reference Q data.
- m_axi_cap_raddr  out  CAP_ADDR_BITS  capture read address.
- m_axi_cap_rvalid  out  1  capture address valid.
- s_axi_cap_rready  in  1  capture buffer accepts the address.
- m_axi_cap_rready  out  1  sequencer ready for capture data.
- s_axi_cap_rvalid  in  1  capture data valid.
- cap_i  in  REC_I_BITS  capture I data.
- cap_q  in  REC_Q_BITS  capture Q data.
- s_axis_tvalid  out  1  output beat valid.
- s_axis_tdata  out  REF_I_BITS+REF_Q_BITS+REC_I_BITS+REC_Q_BITS  packed {cap_q, cap_i, ref_q, ref_i}, ref_i in the LSBs.
- s_axis_tlast  out  1  last beat of the current lag.
- s_axis_tuser  out  clog2(N_LAGS) (min 1)  lag index k of the beat.
- m_axis_tready  in  1  downstream accepts the beat.

Behaviour:
- Reset (n_reset low at a clk edge, from any state):
  - all outputs 0, FSM to IDLE, counters n=k=0, holding registers cleared;
  - any in-flight buffer read is abandoned.
- FSM states: IDLE, ADDR, DATA, EMIT, FIN.
- IDLE:
  - start=1 -> ADDR with n=0, k=0, busy=1;
  - start while busy is ignored;
  - abort in IDLE has no effect.
- ADDR:
  - m_axi_ref_rvalid=1 with raddr=n;
  - m_axi_cap_rvalid=1 with raddr=n+k;
  - each channel's rvalid drops the cycle after its own rready handshake;
  - addresses stay stable while rvalid is high;
  - when both addresses are accepted (same or different cycles) -> DATA.
- DATA:
  - m_axi_ref_rready and m_axi_cap_rready are held high until that channel's data handshake;
  - data is captured into holding registers on the handshake;
  - once both are captured -> EMIT.
- EMIT:
  - s_axis_tvalid=1; tdata, tlast and tuser are held stable until m_axis_tready;
  - tlast = (n == REF_LEN-1); tuser = k.
  - On handshake:
    - if n<REF_LEN-1: n++, -> ADDR;
    - else if k<N_LAGS-1: n=0, k++, -> ADDR;
    - else -> FIN.
- FIN: done=1 for one cycle, busy=0, -> IDLE.
- Minimum cost is 3 cycles per beat (ADDR, DATA, EMIT) with zero-wait buffers. One sweep = REF_LEN*N_LAGS beats.
- Capture address is n+k computed at CAP_ADDR_BITS width. The parameter constraint guarantees no wrap, so there is no modular behaviour.
- abort:
  - latched into a sticky flag;
  - takes effect only in ADDR before any address handshake, or at an EMIT handshake, so no buffer transaction is ever left half-done;
  - then -> FIN (done pulses);
  - a beat pending in EMIT is still delivered.
- start and abort in the same cycle in IDLE: the sweep starts, abort is latched, and the sweep ends before the first address issue (done after 2 cycles, zero beats).
- Data arriving on a channel whose rready is low cannot occur per protocol and is ignored.

Decomposition:
- Package caf_pkg holds:
  - state enum (IDLE/ADDR/DATA/EMIT/FIN);
  - tdata packing field offsets as functions of the width parameters;
  - clog2 helper.
- Sub-module caf_read_chan is instantiated twice (ref, cap). It owns one buffer's address-then-data handshake: issue pulse in, addr in, got flag and held I/Q out.
- The top keeps the n/k counters, FSM, abort latch and stream output.

Test Plan:
- REF_LEN=4, N_LAGS=2, zero-wait buffers with ref[a]=a, cap[a]=0x100+a, tready=1 -> 8 beats:
  - ref addrs 0,1,2,3,0,1,2,3;
  - cap addrs 0,1,2,3,1,2,3,4;
  - tlast on beats 4 and 8; tuser 0,0,0,0,1,1,1,1;
  - done 1 cycle after beat 8.
- Same setup with s_axi_cap_rvalid delayed 5 cycles per read -> identical beats; no tvalid before both data captured; addresses stable while rvalid high.
- tready low for 10 cycles during beat 3 -> tdata, tlast and tuser hold constant; no new buffer address issued until the handshake.
- abort asserted while in DATA of beat 2 -> beat 2 still emitted; no further address issued; done pulses; busy falls. abort in IDLE -> no effect.
- n_reset low mid-sweep (ref address accepted, data pending) -> next cycle all outputs 0, IDLE; a fresh start yields a full correct sweep.
- start pulsed while busy -> ignored; beat count remains exactly REF_LEN*N_LAGS.
